// File: rtl/logip_pkg.sv
// Shared constants and types for the LogIP SUMP command controller.
// Opcodes, the "1ALS" ID reply bytes and the reply FSM state type.
package logip_pkg;

   localparam logic [7:0] OP_RESET    = 8'h00;
   localparam logic [7:0] OP_ARM      = 8'h01;
   localparam logic [7:0] OP_ID       = 8'h02;
   localparam logic [7:0] OP_DIV      = 8'h80;
   localparam logic [7:0] OP_RDDLY    = 8'h81;
   localparam logic [7:0] OP_FLAGS    = 8'h82;
   localparam logic [7:0] OP_TRG_BASE = 8'hC0;

   // Element 0 is sent first.
   localparam logic [3:0][7:0] ID_BYTES = {8'h53, 8'h4C, 8'h41, 8'h31};

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } reply_state_t;

endpackage

// File: rtl/sump_ctrl.sv
// SUMP command decoder: holds capture configuration, emits core control
// pulses and streams the 4-byte ID reply over a valid/ready handshake.
module sump_ctrl #(
   parameter int NUM_STAGES = 4,
   parameter int WORD_BITS  = 8,
   parameter int CMD_WORDS  = 5
) (
   input  logic                          clk_i,
   input  logic                          rst_in,
   input  logic [WORD_BITS*CMD_WORDS-1:0] cmd_i,
   input  logic                          cmd_stb_i,
   input  logic                          done_i,
   output logic                          core_rst_o,
   output logic                          arm_o,
   output logic                          armed_o,
   output logic [NUM_STAGES*32-1:0]      trg_mask_o,
   output logic [NUM_STAGES*32-1:0]      trg_val_o,
   output logic [NUM_STAGES*32-1:0]      trg_cfg_o,
   output logic [23:0]                   div_o,
   output logic [15:0]                   read_cnt_o,
   output logic [15:0]                   delay_cnt_o,
   output logic [31:0]                   flags_o,
   output logic [7:0]                    tx_data_o,
   output logic                          tx_vld_o,
   input  logic                          tx_rdy_i
);
   import logip_pkg::*;

   localparam int CW = WORD_BITS * CMD_WORDS;
   localparam int TW = NUM_STAGES * 32;

   logic [7:0]  short_op_s;
   logic [31:0] param_s;
   logic [1:0]  trg_stage_s;
   logic [1:0]  trg_kind_s;
   logic        do_reset_s, do_arm_s, do_id_s;
   logic        wr_div_s, wr_rddly_s, wr_flags_s, wr_trg_s;

   logic          core_rst_r, arm_r, armed_r, tx_vld_r;
   logic [TW-1:0] trg_mask_r, trg_val_r, trg_cfg_r;
   logic [23:0]   div_r;
   logic [15:0]   read_cnt_r, delay_cnt_r;
   logic [31:0]   flags_r;
   logic [7:0]    tx_data_r;
   logic [1:0]    idx_r;
   reply_state_t  state_r;

   assign short_op_s  = cmd_i[CW-1 -: 8];
   assign param_s     = cmd_i[8 +: 32];
   assign trg_stage_s = cmd_i[3:2];
   assign trg_kind_s  = cmd_i[1:0];

   // Decode one strobed command into single-cycle action requests.
   always_comb begin
      do_reset_s = 1'b0;
      do_arm_s   = 1'b0;
      do_id_s    = 1'b0;
      wr_div_s   = 1'b0;
      wr_rddly_s = 1'b0;
      wr_flags_s = 1'b0;
      wr_trg_s   = 1'b0;
      if (cmd_stb_i) begin
         if (cmd_i[7]) begin
            case (cmd_i[7:0])
               OP_DIV:   wr_div_s   = 1'b1;
               OP_RDDLY: wr_rddly_s = 1'b1;
               OP_FLAGS: wr_flags_s = 1'b1;
               default: begin
                  if ((cmd_i[7:4] == OP_TRG_BASE[7:4]) && (trg_kind_s != 2'd3) &&
                      (int'(trg_stage_s) < NUM_STAGES)) begin
                     wr_trg_s = 1'b1;
                  end else begin
                     wr_trg_s = 1'b0;
                  end
               end
            endcase
         end else begin
            case (short_op_s)
               OP_RESET: do_reset_s = 1'b1;
               OP_ARM:   do_arm_s   = 1'b1;
               OP_ID:    do_id_s    = 1'b1;
               default:  do_id_s    = 1'b0;
            endcase
         end
      end else begin
         do_id_s = 1'b0;
      end
   end

   // Configuration registers, control pulses, armed status and reply FSM.
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         core_rst_r  <= 1'b0;
         arm_r       <= 1'b0;
         armed_r     <= 1'b0;
         trg_mask_r  <= '0;
         trg_val_r   <= '0;
         trg_cfg_r   <= '0;
         div_r       <= 24'd0;
         read_cnt_r  <= 16'd0;
         delay_cnt_r <= 16'd0;
         flags_r     <= 32'd0;
         tx_data_r   <= 8'd0;
         tx_vld_r    <= 1'b0;
         idx_r       <= 2'd0;
         state_r     <= ST_IDLE;
      end else begin
         core_rst_r <= do_reset_s;
         arm_r      <= do_arm_s;
         // Arm takes priority over a simultaneous capture-done.
         if (do_arm_s) begin
            armed_r <= 1'b1;
         end else if (do_reset_s || done_i) begin
            armed_r <= 1'b0;
         end
         if (wr_div_s) div_r <= param_s[23:0];
         if (wr_rddly_s) begin
            read_cnt_r  <= param_s[15:0];
            delay_cnt_r <= param_s[31:16];
         end
         if (wr_flags_s) flags_r <= param_s;
         if (wr_trg_s) begin
            case (trg_kind_s)
               2'd0:    trg_mask_r[int'(trg_stage_s)*32 +: 32] <= param_s;
               2'd1:    trg_val_r[int'(trg_stage_s)*32 +: 32]  <= param_s;
               2'd2:    trg_cfg_r[int'(trg_stage_s)*32 +: 32]  <= param_s;
               default: trg_cfg_r <= trg_cfg_r;
            endcase
         end
         case (state_r)
            ST_IDLE: begin
               if (do_id_s) begin
                  state_r   <= ST_SEND;
                  idx_r     <= 2'd0;
                  tx_vld_r  <= 1'b1;
                  tx_data_r <= ID_BYTES[0];
               end
            end
            ST_SEND: begin
               if (tx_rdy_i) begin
                  if (idx_r == 2'd3) begin
                     state_r  <= ST_IDLE;
                     idx_r    <= 2'd0;
                     tx_vld_r <= 1'b0;
                  end else begin
                     idx_r     <= idx_r + 2'd1;
                     tx_data_r <= ID_BYTES[idx_r + 2'd1];
                  end
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               tx_vld_r <= 1'b0;
            end
         endcase
      end
   end

   assign core_rst_o  = core_rst_r;
   assign arm_o       = arm_r;
   assign armed_o     = armed_r;
   assign trg_mask_o  = trg_mask_r;
   assign trg_val_o   = trg_val_r;
   assign trg_cfg_o   = trg_cfg_r;
   assign div_o       = div_r;
   assign read_cnt_o  = read_cnt_r;
   assign delay_cnt_o = delay_cnt_r;
   assign flags_o     = flags_r;
   assign tx_data_o   = tx_data_r;
   assign tx_vld_o    = tx_vld_r;

endmodule

// File: tb/tb_sump_ctrl.sv
// Self-checking bench for sump_ctrl: directed steps plus random traffic
// compared against a register/queue reference model of the command set.
module tb_sump_ctrl;

   logic         clk_i;
   logic         rst_in;
   logic [39:0]  cmd_i;
   logic         cmd_stb_i;
   logic         done_i;
   logic         core_rst_o, arm_o, armed_o;
   logic [127:0] trg_mask_o, trg_val_o, trg_cfg_o;
   logic [23:0]  div_o;
   logic [15:0]  read_cnt_o, delay_cnt_o;
   logic [31:0]  flags_o;
   logic [7:0]   tx_data_o;
   logic         tx_vld_o;
   logic         tx_rdy_i;

   sump_ctrl dut (
      .clk_i(clk_i), .rst_in(rst_in), .cmd_i(cmd_i), .cmd_stb_i(cmd_stb_i),
      .done_i(done_i), .core_rst_o(core_rst_o), .arm_o(arm_o), .armed_o(armed_o),
      .trg_mask_o(trg_mask_o), .trg_val_o(trg_val_o), .trg_cfg_o(trg_cfg_o),
      .div_o(div_o), .read_cnt_o(read_cnt_o), .delay_cnt_o(delay_cnt_o),
      .flags_o(flags_o), .tx_data_o(tx_data_o), .tx_vld_o(tx_vld_o),
      .tx_rdy_i(tx_rdy_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Reference model state.
   logic [31:0] m_mask [4];
   logic [31:0] m_val  [4];
   logic [31:0] m_cfg  [4];
   logic [23:0] m_div;
   logic [15:0] m_rd, m_dly;
   logic [31:0] m_flags;
   logic        m_armed, m_rst_p, m_arm_p;
   logic [7:0]  m_q [$];

   int errors = 0;
   int checks = 0;

   localparam logic [39:0] C_ID  = 40'h02_0000_0000;
   localparam logic [39:0] C_ARM = 40'h01_0000_0000;
   localparam logic [39:0] C_RST = 40'h00_0000_0000;

   task automatic model_clear();
      for (int s = 0; s < 4; s++) begin
         m_mask[s] = 32'd0; m_val[s] = 32'd0; m_cfg[s] = 32'd0;
      end
      m_div = 24'd0; m_rd = 16'd0; m_dly = 16'd0; m_flags = 32'd0;
      m_armed = 1'b0; m_rst_p = 1'b0; m_arm_p = 1'b0;
      m_q.delete();
   endtask

   // What one clock edge does to the model, given the inputs in front of it.
   task automatic model_edge(input logic stb, input logic [39:0] cmd,
                             input logic done, input logic rdy);
      logic [7:0]  op;
      logic [31:0] p;
      bit          busy;
      int          st, k;
      busy    = (m_q.size() != 0);
      m_rst_p = 1'b0;
      m_arm_p = 1'b0;
      p       = cmd[39:8];
      if (busy && rdy) void'(m_q.pop_front());
      if (done) m_armed = 1'b0;
      if (stb) begin
         if (cmd[7] == 1'b0) begin
            op = cmd[39:32];
            if (op == 8'h00) begin m_rst_p = 1'b1; m_armed = 1'b0; end
            if (op == 8'h01) begin m_arm_p = 1'b1; m_armed = 1'b1; end
            if (op == 8'h02 && !busy) begin
               m_q.push_back(8'h31); m_q.push_back(8'h41);
               m_q.push_back(8'h4C); m_q.push_back(8'h53);
            end
         end else begin
            op = cmd[7:0];
            st = (int'(op) - 'hC0) / 4;
            k  = (int'(op) - 'hC0) % 4;
            if (op >= 8'hC0 && op <= 8'hCF && k == 0) m_mask[st] = p;
            if (op >= 8'hC0 && op <= 8'hCF && k == 1) m_val[st]  = p;
            if (op >= 8'hC0 && op <= 8'hCF && k == 2) m_cfg[st]  = p;
            if (op == 8'h80) m_div = p[23:0];
            if (op == 8'h81) begin m_rd = p[15:0]; m_dly = p[31:16]; end
            if (op == 8'h82) m_flags = p;
         end
      end
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".core_rst"}, 128'(core_rst_o), 128'(m_rst_p));
      check({tag, ".arm"},      128'(arm_o),      128'(m_arm_p));
      check({tag, ".armed"},    128'(armed_o),    128'(m_armed));
      check({tag, ".mask"}, trg_mask_o, {m_mask[3], m_mask[2], m_mask[1], m_mask[0]});
      check({tag, ".val"},  trg_val_o,  {m_val[3], m_val[2], m_val[1], m_val[0]});
      check({tag, ".cfg"},  trg_cfg_o,  {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]});
      check({tag, ".div"},   128'(div_o),       128'(m_div));
      check({tag, ".rd"},    128'(read_cnt_o),  128'(m_rd));
      check({tag, ".dly"},   128'(delay_cnt_o), 128'(m_dly));
      check({tag, ".flags"}, 128'(flags_o),     128'(m_flags));
      check({tag, ".tx_vld"}, 128'(tx_vld_o), 128'(m_q.size() != 0));
      if (m_q.size() != 0) check({tag, ".tx_data"}, 128'(tx_data_o), 128'(m_q[0]));
   endtask

   // One clock: drive inputs, advance the model, sample just after the edge.
   task automatic cyc(input string tag, input logic stb, input logic [39:0] cmd,
                      input logic done, input logic rdy);
      cmd_i = stb ? cmd : {$urandom(), 8'($urandom())};
      cmd_stb_i = stb; done_i = done; tx_rdy_i = rdy;
      model_edge(stb, cmd, done, rdy);
      @(posedge clk_i); #1;
      cmd_stb_i = 1'b0; done_i = 1'b0;
      check_all(tag);
   endtask

   function automatic logic [39:0] rand_cmd();
      logic [31:0] p;
      logic [7:0]  op;
      p = $urandom();
      case ($urandom_range(0, 5))
         0: begin
            op = 8'($urandom_range(0, 5));
            if (op == 8'h03) op = 8'h11;
            if (op == 8'h04) op = 8'h13;
            if (op == 8'h05) op = 8'($urandom_range(0, 127));
            return {op, p[31:8], 1'b0, p[6:0]};
         end
         1, 2: return {p, 8'($urandom_range('hC0, 'hCF))};
         3: return {p, 8'($urandom_range('h80, 'h82))};
         default: return {p, 8'($urandom_range('h80, 'hFF))};
      endcase
   endfunction

   initial begin
      rst_in = 1'b0; cmd_i = 40'd0; cmd_stb_i = 1'b0; done_i = 1'b0; tx_rdy_i = 1'b0;
      model_clear();
      @(posedge clk_i); @(posedge clk_i); #1;
      check_all("reset");
      rst_in = 1'b1;

      // ID reply with ready held high: four consecutive bytes, then idle.
      cyc("id0", 1'b1, C_ID, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc("id_fast", 1'b0, 40'd0, 1'b0, 1'b1);

      // ID reply with ready toggling and a second ID mid-reply.
      cyc("id1", 1'b1, C_ID, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++)
         cyc("id_slow", (i == 3), C_ID, 1'b0, (i % 4 == 0) || (i % 4 == 3));
      for (int i = 0; i < 3; i++) cyc("id_drain", 1'b0, 40'd0, 1'b0, 1'b1);

      cyc("mask1",  1'b1, 40'hDEADBEEF_C4, 1'b0, 1'b0);
      cyc("rddly",  1'b1, 40'h001000FF_81, 1'b0, 1'b0);
      cyc("div",    1'b1, 40'h12345678_80, 1'b0, 1'b0);
      cyc("flags",  1'b1, 40'hA5A5_0F0F_82, 1'b0, 1'b0);
      cyc("cfg3",   1'b1, 40'h0BAD_F00D_CE, 1'b0, 1'b0);

      cyc("arm",      1'b1, C_ARM, 1'b0, 1'b0);
      cyc("arm_idle", 1'b0, 40'd0, 1'b0, 1'b0);
      cyc("done",     1'b0, 40'd0, 1'b1, 1'b0);
      cyc("arm_done", 1'b1, C_ARM, 1'b1, 1'b0);
      cyc("rst_cmd",  1'b1, C_RST, 1'b0, 1'b0);
      cyc("rst_idle", 1'b0, 40'd0, 1'b0, 1'b0);

      cyc("ign_c3", 1'b1, 40'hFFFFFFFF_C3, 1'b0, 1'b0);
      cyc("ign_11", 1'b1, 40'h11_0000_0000, 1'b0, 1'b0);
      cyc("ign_7f", 1'b1, 40'h7F_0000_0000, 1'b0, 1'b0);

      // Random traffic including back-to-back strobes.
      for (int i = 0; i < 400; i++)
         cyc("rand", ($urandom_range(0, 1) == 1), rand_cmd(),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1));
      for (int i = 0; i < 5; i++) cyc("rand_drain", 1'b0, 40'd0, 1'b0, 1'b1);

      // Asynchronous reset while the third ID byte is pending.
      cyc("rr_id", 1'b1, C_ID, 1'b0, 1'b0);
      cyc("rr_b1", 1'b0, 40'd0, 1'b0, 1'b1);
      cyc("rr_b2", 1'b0, 40'd0, 1'b0, 1'b1);
      check("rr_idx2", 128'(tx_data_o), 128'(8'h4C));
      tx_rdy_i = 1'b0;
      #2 rst_in = 1'b0;
      #1 model_clear();
      check_all("async_rst");
      check("async_rst.tx_data", 128'(tx_data_o), 128'(8'h00));
      @(posedge clk_i); #1;
      rst_in = 1'b1;
      check_all("rst_hold");
      cyc("rr_new", 1'b1, C_ID, 1'b0, 1'b1);
      check("rr_first", 128'(tx_data_o), 128'(8'h31));
      for (int i = 0; i < 5; i++) cyc("rr_tail", 1'b0, 40'd0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
